// File: rtl/ternary_fold_sequencer.sv
// +---------------------------------------------------------------------------+
// | ternary_fold_sequencer: folds a trit stream through one shared op unit    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module ternary_fold_sequencer #(
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       in_trit_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [1:0]       res_trit_o,
  output logic             res_err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRST = 2'd1,
    S_FOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_MIN = 2'b00;
  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_ANY = 2'b10;

  state_t           state_q, state_d;
  logic [1:0]       acc_q, acc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [1:0]       op_q, op_d;
  logic             cmd_ready_q, in_ready_q, res_valid_q, busy_q;

  logic [1:0]       trit_clean;
  logic             trit_bad;

  // The single shared op unit; operands are always sanitized trits (0..2).
  function automatic logic [1:0] op_apply(input logic [1:0] op,
                                          input logic [1:0] x,
                                          input logic [1:0] y);
    logic [2:0] sum;
    logic [1:0] r;
    sum = {1'b0, x} + {1'b0, y};
    case (op)
      OP_MIN:  r = (x < y) ? x : y;
      OP_MAX:  r = (x > y) ? x : y;
      OP_ANY: begin
        if (sum == 3'd0)      r = 2'd0;
        else if (sum >= 3'd3) r = 2'd2;
        else                  r = sum[1:0] - 2'd1;
      end
      default: r = (x == y) ? x : 2'd1;
    endcase
    return r;
  endfunction

  assign trit_bad   = (in_trit_i == 2'b11);
  assign trit_clean = trit_bad ? 2'b00 : in_trit_i;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          op_d    = cmd_op_i;
          cnt_d   = cmd_len_i;
          err_d   = 1'b0;
          state_d = S_FIRST;
        end
      end
      S_FIRST: begin
        if (in_valid_i) begin
          acc_d = trit_clean;
          err_d = trit_bad;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = cnt_q - 1'b1;
            state_d = S_FOLD;
          end
        end
      end
      S_FOLD: begin
        if (in_valid_i) begin
          acc_d = op_apply(op_q, acc_q, trit_clean);
          err_d = err_q | trit_bad;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        if (res_ready_i) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Handshake flags are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      acc_q       <= 2'b00;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      op_q        <= 2'b00;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      op_q        <= op_d;
      cmd_ready_q <= (state_d == S_IDLE);
      in_ready_q  <= (state_d == S_FIRST) || (state_d == S_FOLD);
      res_valid_q <= (state_d == S_DONE);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign in_ready_o  = in_ready_q;
  assign res_valid_o = res_valid_q;
  assign res_trit_o  = acc_q;
  assign res_err_o   = err_q;
  assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ternary_fold_sequencer.sv
// +---------------------------------------------------------------------------+
// | tb_ternary_fold_sequencer: scoreboard bench for ternary_fold_sequencer    |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_ternary_fold_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       in_valid, in_ready;
  logic [1:0] in_trit;
  logic       res_valid, res_ready;
  logic [1:0] res_trit;
  logic       res_err;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_q[$];   // {err, trit}
  logic [1:0] tv[16];

  always #5 clk = ~clk;

  ternary_fold_sequencer #(.LEN_W(4)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_len_i   (cmd_len),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_trit_i   (in_trit),
    .res_valid_o (res_valid),
    .res_ready_i (res_ready),
    .res_trit_o  (res_trit),
    .res_err_o   (res_err),
    .busy_o      (busy)
  );

  function automatic int ref_op(input int op, input int x, input int y);
    int s;
    case (op)
      0: return (x < y) ? x : y;
      1: return (x > y) ? x : y;
      2: begin
        s = x + y - 1;
        if (s < 0) s = 0;
        if (s > 2) s = 2;
        return s;
      end
      default: return (x == y) ? x : 1;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [3:0] len);
    int n = 0;
    cmd_op    = op;
    cmd_len   = len;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin tick(); n++; end
    if (!cmd_ready) begin
      $display("FAIL cmd_timeout: cmd_ready=%0b required 1", cmd_ready);
      $fatal(1, "command handshake timed out");
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_trit(input logic [1:0] t);
    int n = 0;
    in_trit  = t;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) begin
      $display("FAIL in_timeout: in_ready=%0b required 1", in_ready);
      $fatal(1, "trit handshake timed out");
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_res();
    int n = 0;
    while (!res_valid && n < 200) begin tick(); n++; end
    if (!res_valid) begin
      $display("FAIL res_timeout: res_valid=%0b required 1", res_valid);
      $fatal(1, "result timed out");
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  // Drives one command plus its trits from tv[0..len], with random idle gaps.
  task automatic run_seq(input logic [1:0] op, input int len, input int gapmax);
    send_cmd(op, 4'(len));
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, gapmax)) tick();
      send_trit(tv[i]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    n_tests++; if (res_trit !== 2'b00) begin n_fail++; $display("FAIL reset_res_trit: got %b want 00", res_trit); end
    n_tests++; if (res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err: got %b want 0", res_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_max_latency();
    logic [2:0] e;
    send_cmd(2'b01, 4'd2);
    exp_q.push_back(3'b0_10);
    send_trit(2'd0);
    send_trit(2'd1);
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL max_early_valid: got %b want 0", res_valid); end
    send_trit(2'd2);
    n_tests++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL max_latency: res_valid got %b want 1", res_valid); end
    wait_res();
    e = exp_q.pop_front();
    n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL max_trit: got %b want %b", res_trit, e[1:0]); end
    n_tests++; if (res_err !== e[2]) begin n_fail++; $display("FAIL max_err: got %b want %b", res_err, e[2]); end
    consume();
    n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL max_valid_drop: got %b want 0", res_valid); end
  endtask

  task automatic test_min_single();
    logic [2:0] e;
    send_cmd(2'b00, 4'd0);
    exp_q.push_back(3'b0_10);
    send_trit(2'd2);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL single_in_ready: got %b want 0", in_ready); end
    wait_res();
    e = exp_q.pop_front();
    n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL single_trit: got %b want %b", res_trit, e[1:0]); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_done: got %b want 1", busy); end
    consume();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", busy); end
  endtask

  task automatic test_ops();
    logic [2:0] e;
    logic [1:0] ops[4]   = '{2'b10, 2'b11, 2'b11, 2'b10};
    int         lens[4]  = '{2, 2, 1, 1};
    logic [5:0] trits[4] = '{6'b10_01_01, 6'b00_10_10, 6'b00_01_01, 6'b00_00_00};
    logic [1:0] want[4]  = '{2'b10, 2'b01, 2'b01, 2'b00};
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) tv[i] = trits[k][2*i +: 2];
      exp_q.push_back({1'b0, want[k]});
      run_seq(ops[k], lens[k], 0);
      wait_res();
      e = exp_q.pop_front();
      n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL ops_%0d_trit: got %b want %b", k, res_trit, e[1:0]); end
      n_tests++; if (res_err !== e[2]) begin n_fail++; $display("FAIL ops_%0d_err: got %b want %b", k, res_err, e[2]); end
      consume();
    end
  endtask

  task automatic test_invalid();
    logic [2:0] e;
    tv[0] = 2'b01; tv[1] = 2'b11; tv[2] = 2'b00;
    exp_q.push_back(3'b1_01);
    run_seq(2'b01, 2, 0);
    wait_res();
    e = exp_q.pop_front();
    n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL inv_trit: got %b want %b", res_trit, e[1:0]); end
    n_tests++; if (res_err !== e[2]) begin n_fail++; $display("FAIL inv_err: got %b want %b", res_err, e[2]); end
    consume();
    tv[0] = 2'b10; tv[1] = 2'b01;
    exp_q.push_back(3'b0_01);
    run_seq(2'b00, 1, 0);
    wait_res();
    e = exp_q.pop_front();
    n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL inv_next_trit: got %b want %b", res_trit, e[1:0]); end
    n_tests++; if (res_err !== e[2]) begin n_fail++; $display("FAIL inv_next_err: got %b want %b", res_err, e[2]); end
    consume();
  endtask

  task automatic test_random();
    logic [2:0] e;
    int acc, v;
    bit err;
    for (int op = 0; op < 4; op++) begin
      for (int n = 1; n <= 16; n++) begin
        acc = 0;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
          tv[i] = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
          v   = (tv[i] == 2'b11) ? 0 : int'(tv[i]);
          err = err | (tv[i] == 2'b11);
          acc = (i == 0) ? v : ref_op(op, acc, v);
        end
        exp_q.push_back({err, 2'(acc)});
        run_seq(2'(op), n - 1, 2);
        wait_res();
        e = exp_q.pop_front();
        if (n % 3 == 0) begin
          for (int s = 0; s < 5; s++) begin
            tick();
            n_tests++; if (res_valid !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hs op%0d n%0d: valid=%b cmd_ready=%b want 1/0", op, n, res_valid, cmd_ready); end
            n_tests++; if ({res_err, res_trit} !== e) begin n_fail++; $display("FAIL stall_hold op%0d n%0d: got %b want %b", op, n, {res_err, res_trit}, e); end
          end
        end
        n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL rand_trit op%0d n%0d: got %b want %b", op, n, res_trit, e[1:0]); end
        n_tests++; if (res_err !== e[2]) begin n_fail++; $display("FAIL rand_err op%0d n%0d: got %b want %b", op, n, res_err, e[2]); end
        consume();
        n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rand_cmd_ready op%0d n%0d: got %b want 1", op, n, cmd_ready); end
      end
    end
  endtask

  task automatic test_reset_midfold();
    logic [2:0] e;
    send_cmd(2'b01, 4'd3);
    send_trit(2'd2);
    send_trit(2'd1);
    in_trit  = 2'd2;
    in_valid = 1'b1;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    n_tests++; if (cmd_ready !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready: cmd=%b in=%b want 1/0", cmd_ready, in_ready); end
    n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_valid_busy: valid=%b busy=%b want 0/0", res_valid, busy); end
    n_tests++; if (res_trit !== 2'b00 || res_err !== 1'b0) begin n_fail++; $display("FAIL mid_res: trit=%b err=%b want 00/0", res_trit, res_err); end
    tv[0] = 2'd0; tv[1] = 2'd0;
    exp_q.push_back(3'b0_00);
    run_seq(2'b11, 1, 0);
    wait_res();
    e = exp_q.pop_front();
    n_tests++; if (res_trit !== e[1:0]) begin n_fail++; $display("FAIL mid_new_trit: got %b want %b", res_trit, e[1:0]); end
    n_tests++; if (res_err !== e[2]) begin n_fail++; $display("FAIL mid_new_err: got %b want %b", res_err, e[2]); end
    consume();
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 4'd0;
    in_valid  = 1'b0;
    in_trit   = 2'b00;
    res_ready = 1'b0;
    #1;
    test_reset();
    test_max_latency();
    test_min_single();
    test_ops();
    test_invalid();
    test_random();
    test_reset_midfold();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
